ln_stat_replay: RTL and testbench

LN_STAT_REPLAY -- requirements
Module: ln_stat_replay

---
 rtl/ln_stat_replay_pkg.sv | 13 +
 rtl/ln_stat_replay_center_buf.sv | 24 ++
 rtl/ln_stat_replay.sv | 149 ++++++++++++++
 tb/tb_ln_stat_replay.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ln_stat_replay_pkg.sv
// Shared widths and FSM encoding for the layer-norm statistics replay block.
package ln_stat_replay_pkg;

   localparam int unsigned LN_DW        = 16;
   localparam int unsigned LN_TOUT      = 32;
   localparam int unsigned LN_LOG2_TOUT = 5;

   typedef enum logic {
      ST_FILL   = 1'b0,
      ST_REPLAY = 1'b1
   } ln_state_e;

endpackage

// File: rtl/ln_stat_replay_center_buf.sv
// Simple dual-port statistics buffer: one write port, one read port with a registered read.
module ln_stat_replay_center_buf #(
   parameter int unsigned W     = 48,
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/ln_stat_replay.sv
// Buffers per-lane mean/variance for one group of lanes, then replays them against
// streamed samples to produce centred, saturated data with the matching variance.
module ln_stat_replay
   import ln_stat_replay_pkg::*;
#(
   parameter int unsigned DW        = LN_DW,
   parameter int unsigned TOUT      = LN_TOUT,
   parameter int unsigned LOG2_TOUT = LN_LOG2_TOUT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stat_vld_i,
   input  logic signed [DW-1:0]   stat_mean_i,
   input  logic signed [2*DW-1:0] stat_sq_i,
   output logic                   stat_rdy_o,
   input  logic                   dat_vld_i,
   input  logic signed [DW-1:0]   dat_i,
   input  logic                   Stripe_loop_end,
   input  logic                   CH_and_Stripe_loop_end,
   output logic                   dat_rdy_o,
   output logic                   dat_out_vld,
   output logic signed [DW-1:0]   dat_out,
   output logic [2*DW-1:0]        var_out,
   output logic                   proto_err_o
);

   localparam int unsigned         WW   = 3 * DW;
   localparam logic [LOG2_TOUT-1:0] LAST = LOG2_TOUT'(TOUT - 1);
   localparam logic [DW-1:0]        SMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0]        SMIN = {1'b1, {(DW-1){1'b0}}};

   ln_state_e              state;
   logic                   fill_done;
   logic [LOG2_TOUT-1:0]   fill_ptr;
   logic [LOG2_TOUT-1:0]   rd_ptr;
   logic                   wr_vld;
   logic [LOG2_TOUT-1:0]   wr_addr;
   logic [WW-1:0]          wr_data;
   logic                   p1_vld;
   logic signed [DW-1:0]   p1_dat;
   logic [WW-1:0]          rd_data;

   logic                   stat_acc;
   logic                   dat_acc;
   logic signed [2*DW-1:0] mean_sq;
   logic signed [2*DW:0]   var_raw;
   logic [2*DW-1:0]        var_clamped;
   logic signed [DW-1:0]   rd_mean;
   logic signed [DW:0]     diff;
   logic signed [DW-1:0]   diff_sat;

   // Buffer word layout is {mean, variance}.
   always_comb begin
      stat_acc    = stat_vld_i && stat_rdy_o;
      dat_acc     = dat_vld_i && dat_rdy_o;
      mean_sq     = (2*DW)'(stat_mean_i) * (2*DW)'(stat_mean_i);
      var_raw     = $signed({stat_sq_i[2*DW-1], stat_sq_i}) - $signed({mean_sq[2*DW-1], mean_sq});
      var_clamped = var_raw[2*DW] ? '0 : var_raw[2*DW-1:0];
      rd_mean     = rd_data[WW-1 -: DW];
      diff        = $signed({p1_dat[DW-1], p1_dat}) - $signed({rd_mean[DW-1], rd_mean});
      diff_sat    = diff[DW-1:0];
      if (diff[DW:DW-1] == 2'b01) diff_sat = SMAX;
      if (diff[DW:DW-1] == 2'b10) diff_sat = SMIN;
   end

   ln_stat_replay_center_buf #(
      .W     (WW),
      .DEPTH (TOUT),
      .AW    (LOG2_TOUT)
   ) center_buf (
      .clk     (clk),
      .wr_en   (wr_vld),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (dat_acc),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   // fill_done marks the cycle where the last lane's write is committing; REPLAY follows it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_FILL;
         fill_done   <= 1'b0;
         fill_ptr    <= '0;
         rd_ptr      <= '0;
         stat_rdy_o  <= 1'b1;
         dat_rdy_o   <= 1'b0;
         wr_vld      <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         p1_vld      <= 1'b0;
         p1_dat      <= '0;
         dat_out_vld <= 1'b0;
         dat_out     <= '0;
         var_out     <= '0;
         proto_err_o <= 1'b0;
      end else begin
         proto_err_o <= (stat_vld_i && !stat_rdy_o) || (dat_vld_i && !dat_rdy_o);
         wr_vld      <= stat_acc;
         if (stat_acc) begin
            wr_addr <= fill_ptr;
            wr_data <= {stat_mean_i, var_clamped};
         end
         p1_vld <= dat_acc;
         if (dat_acc) p1_dat <= dat_i;
         dat_out_vld <= p1_vld;
         if (p1_vld) begin
            dat_out <= diff_sat;
            var_out <= rd_data[2*DW-1:0];
         end
         case (state)
            ST_FILL: begin
               if (fill_done) begin
                  state     <= ST_REPLAY;
                  fill_done <= 1'b0;
                  rd_ptr    <= '0;
                  dat_rdy_o <= 1'b1;
               end else if (stat_acc) begin
                  if (fill_ptr == LAST) begin
                     fill_ptr   <= '0;
                     fill_done  <= 1'b1;
                     stat_rdy_o <= 1'b0;
                  end else begin
                     fill_ptr <= fill_ptr + LOG2_TOUT'(1);
                  end
               end
            end
            ST_REPLAY: begin
               if (dat_acc) begin
                  if (CH_and_Stripe_loop_end) begin
                     state      <= ST_FILL;
                     fill_ptr   <= '0;
                     rd_ptr     <= '0;
                     stat_rdy_o <= 1'b1;
                     dat_rdy_o  <= 1'b0;
                  end else if (Stripe_loop_end || rd_ptr == LAST) begin
                     rd_ptr <= '0;
                  end else begin
                     rd_ptr <= rd_ptr + LOG2_TOUT'(1);
                  end
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_ln_stat_replay.sv
// Directed plus randomized bench for ln_stat_replay at DW=16, TOUT=4 against a per-lane array model.
module tb_ln_stat_replay;

   localparam int TOUT = 4;

   logic        clk;
   logic        rst;
   logic        stat_vld_i;
   logic [15:0] stat_mean_i;
   logic [31:0] stat_sq_i;
   logic        stat_rdy_o;
   logic        dat_vld_i;
   logic [15:0] dat_i;
   logic        Stripe_loop_end;
   logic        CH_and_Stripe_loop_end;
   logic        dat_rdy_o;
   logic        dat_out_vld;
   logic [15:0] dat_out;
   logic [31:0] var_out;
   logic        proto_err_o;

   int checks = 0;
   int errors = 0;

   // Reference model: lane tables, fill count, replay pointer, one pending output.
   int          m_mean [TOUT];
   longint      m_var  [TOUT];
   bit          m_fill;
   int          m_cnt;
   int          m_ptr;
   bit          pv_vld;
   logic [15:0] pv_dat;
   logic [31:0] pv_var;

   ln_stat_replay #(.DW(16), .TOUT(4), .LOG2_TOUT(2)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .stat_vld_i             (stat_vld_i),
      .stat_mean_i            (stat_mean_i),
      .stat_sq_i              (stat_sq_i),
      .stat_rdy_o             (stat_rdy_o),
      .dat_vld_i              (dat_vld_i),
      .dat_i                  (dat_i),
      .Stripe_loop_end        (Stripe_loop_end),
      .CH_and_Stripe_loop_end (CH_and_Stripe_loop_end),
      .dat_rdy_o              (dat_rdy_o),
      .dat_out_vld            (dat_out_vld),
      .dat_out                (dat_out),
      .var_out                (var_out),
      .proto_err_o            (proto_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat16(input int r);
      if (r > 32767) return 32767;
      if (r < -32768) return -32768;
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      stat_vld_i = 1'b0; dat_vld_i = 1'b0;
      Stripe_loop_end = 1'b0; CH_and_Stripe_loop_end = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_vld", dat_out_vld, 1'b0);
      chk("rst_dat", dat_out, 16'h0);
      chk("rst_var", var_out, 32'h0);
      chk("rst_err", proto_err_o, 1'b0);
      chk("rst_stat_rdy", stat_rdy_o, 1'b1);
      chk("rst_dat_rdy", dat_rdy_o, 1'b0);
      rst = 1'b0;
      m_fill = 1'b1; m_cnt = 0; m_ptr = 0; pv_vld = 1'b0;
   endtask

   // One clock: check readies, drive inputs, update the model, then check outputs of the previous beat.
   task automatic step(input bit sv, input int mean, input longint sq,
                       input bit dv, input int d, input bit sle, input bit ch);
      bit          srdy, drdy, gap, err, nvld;
      logic [15:0] ndat;
      logic [31:0] nvar;
      longint      v;
      srdy = m_fill && (m_cnt < TOUT);
      drdy = !m_fill;
      gap  = m_fill && (m_cnt == TOUT);
      chk("stat_rdy", stat_rdy_o, srdy);
      chk("dat_rdy", dat_rdy_o, drdy);
      stat_vld_i = sv; stat_mean_i = 16'(mean); stat_sq_i = 32'(sq);
      dat_vld_i = dv; dat_i = 16'(d);
      Stripe_loop_end = sle || ch; CH_and_Stripe_loop_end = ch;
      err = 1'b0; nvld = 1'b0; ndat = '0; nvar = '0;
      if (sv) begin
         if (srdy) begin
            m_mean[m_cnt] = mean;
            v = sq - longint'(mean) * longint'(mean);
            m_var[m_cnt] = (v < 0) ? 0 : v;
            m_cnt++;
         end else err = 1'b1;
      end
      if (dv) begin
         if (drdy) begin
            nvld = 1'b1;
            ndat = 16'(sat16(d - m_mean[m_ptr]));
            nvar = 32'(m_var[m_ptr]);
            if (sle || ch || m_ptr == TOUT - 1) m_ptr = 0;
            else m_ptr++;
            if (ch) begin m_fill = 1'b1; m_cnt = 0; end
         end else err = 1'b1;
      end
      if (gap) begin m_fill = 1'b0; m_ptr = 0; end
      @(posedge clk); #1;
      chk("proto_err", proto_err_o, err);
      chk("out_vld", dat_out_vld, pv_vld);
      if (pv_vld) begin
         chk("dat_out", dat_out, pv_dat);
         chk("var_out", var_out, pv_var);
      end
      pv_vld = nvld; pv_dat = ndat; pv_var = nvar;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic fill(input int mn[4], input longint sq[4]);
      for (int i = 0; i < 4; i++) step(1, mn[i], sq[i], 0, 0, 0, 0);
      idle(1);
   endtask

   task automatic beat(input int d, input bit sle, input bit ch);
      step(0, 0, 0, 1, d, sle, ch);
   endtask

   initial begin
      int     rm, rd;
      longint rs;
      bit     last;
      rst = 1'b1;
      stat_vld_i = 1'b0; stat_mean_i = '0; stat_sq_i = '0;
      dat_vld_i = 1'b0; dat_i = '0;
      Stripe_loop_end = 1'b0; CH_and_Stripe_loop_end = 1'b0;
      do_reset();

      // Basic fill and a 12-beat continuous replay with a stripe end every 4th beat.
      fill('{10, -5, 0, 100}, '{200, 25, 0, 10000});
      for (int i = 0; i < 12; i++) beat(110, (i % 4) == 3, 1'b0);
      step(1, 999, 5, 0, 0, 0, 0);
      beat(110, 0, 0);
      beat(110, 0, 0);
      beat(110, 0, 1);
      step(0, 0, 0, 1, 5, 0, 0);

      // Clamped variance and saturation corners on a fresh fill.
      fill('{10, 1, -1, 7}, '{50, 0, 5, 49});
      beat(0, 0, 0);
      beat(-32768, 0, 0);
      beat(32767, 0, 0);
      beat(-32768, 0, 1);
      idle(1);

      // Reset mid-fill, then reset with a replay beat in flight.
      step(1, 3, 9, 0, 0, 0, 0);
      step(1, 4, 16, 0, 0, 0, 0);
      do_reset();
      fill('{-20, 30, 5, -1}, '{400, 1000, 20, 1});
      beat(5, 0, 0);
      do_reset();
      idle(1);
      fill('{-300, 300, 1234, -32768}, '{100000, 90000, 2000000, 1073741824});
      beat(-100, 0, 0);
      beat(100, 0, 0);
      beat(-32000, 0, 0);
      beat(32767, 1, 1);
      idle(2);

      // Randomized rounds with gaps, stripe ends and protocol noise.
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 60 && m_fill; k++) begin
            rm = int'($urandom_range(0, 65535)) - 32768;
            rs = $urandom_range(0, 1) ? longint'(rm) * longint'(rm) + longint'($urandom_range(0, 1000))
                                      : longint'($urandom_range(0, 3000));
            rd = int'($urandom_range(0, 65535)) - 32768;
            step($urandom_range(0, 3) != 0, rm, rs, $urandom_range(0, 7) == 0, rd, 0, 0);
         end
         for (int k = 0; k < 20; k++) begin
            last = (k == 19);
            rd = int'($urandom_range(0, 65535)) - 32768;
            step($urandom_range(0, 7) == 0, 1, 1, last || ($urandom_range(0, 3) != 0), rd,
                 $urandom_range(0, 4) == 0, last);
         end
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
